// File: rtl/adc_align_pkg.sv
// Shared types and helpers for the ADC lane alignment controller.
// Rotation helpers operate on the 6-bit deserializer word.
package adc_align_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCal,
        StDrst,
        StScanWait,
        StScanChk,
        StStep,
        StSetRst,
        StSetInc,
        StSlipWait,
        StSlipChk,
        StSlip,
        StFin
    } state_e;

    function automatic logic [5:0] rotl6(input logic [5:0] word, input logic [2:0] n);
        logic [11:0] dbl;
        dbl = {word, word} << n;
        return dbl[11:6];
    endfunction

    function automatic logic is_rotation(input logic [5:0] word, input logic [5:0] pat);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (word == rotl6(pat, 3'(i))) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/adc_align_cmp.sv
// Registers the deserializer word once and flags exact / any-rotation matches
// against the training pattern.
module adc_align_cmp
    import adc_align_pkg::*;
#(
    parameter logic [5:0] PATTERN = 6'b111000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] din,
    output logic       match_exact,
    output logic       match_rot
);

    logic [5:0] din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= '0;
        end else begin
            din_q <= din;
        end
    end

    assign match_exact = (din_q == PATTERN);
    assign match_rot   = is_rotation(din_q, PATTERN);

endmodule

// File: rtl/adc_lane_align.sv
// Per-lane link training: scan IODELAY taps for the widest eye, centre the delay,
// then bitslip until the word is frame-aligned.
module adc_lane_align
    import adc_align_pkg::*;
#(
    parameter logic [5:0]  PATTERN  = 6'b111000,
    parameter int unsigned TAPS     = 64,
    parameter int unsigned NCHECK   = 64,
    parameter int unsigned SETTLE   = 8,
    parameter int unsigned CAL_WAIT = 32,
    parameter int unsigned NSLIP    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] din,
    output logic       bs,
    output logic       del_ce,
    output logic       del_rst,
    output logic       del_cal,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] tap
);

    localparam int unsigned WaitMax = (CAL_WAIT > SETTLE) ? CAL_WAIT : SETTLE;
    localparam int unsigned WaitW   = $clog2(WaitMax + 1);
    localparam int unsigned CheckW  = $clog2(NCHECK + 1);
    localparam int unsigned SlipW   = $clog2(NSLIP + 1);

    state_e            state_q, state_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [CheckW-1:0] chk_q, chk_d;
    logic [SlipW-1:0]  slip_q, slip_d;
    logic [8:0]        tap_cur_q, tap_cur_d;
    logic [8:0]        run_start_q, run_start_d, run_len_q, run_len_d;
    logic [8:0]        best_start_q, best_start_d, best_len_q, best_len_d;
    logic [8:0]        target_q, target_d, inc_q, inc_d;
    logic              bs_q, bs_d, del_ce_q, del_ce_d, del_rst_q, del_rst_d;
    logic              del_cal_q, del_cal_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [7:0]        tap_q, tap_d;
    logic              match_exact, match_rot;

    adc_align_cmp #(
        .PATTERN(PATTERN)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .match_exact(match_exact),
        .match_rot  (match_rot)
    );

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        chk_d        = chk_q;
        slip_d       = slip_q;
        tap_cur_d    = tap_cur_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        target_d     = target_q;
        inc_d        = inc_q;
        bs_d         = 1'b0;
        del_ce_d     = 1'b0;
        del_rst_d    = 1'b0;
        del_cal_d    = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        tap_d        = tap_q;

        // Strobes are registered: a strobe set here is visible in the next state's first cycle.
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    tap_d        = '0;
                    busy_d       = 1'b1;
                    run_start_d  = '0;
                    run_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    slip_d       = '0;
                    del_cal_d    = 1'b1;
                    wait_d       = WaitW'(CAL_WAIT);
                    state_d      = StCal;
                end
            end
            StCal: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    del_rst_d = 1'b1;
                    state_d   = StDrst;
                end
            end
            StDrst: begin
                tap_cur_d = '0;
                wait_d    = WaitW'(SETTLE - 1);
                state_d   = StScanWait;
            end
            StScanWait: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    chk_d   = '0;
                    state_d = StScanChk;
                end
            end
            StScanChk: begin
                if (!match_rot) begin
                    if (run_len_q > best_len_q) begin
                        best_start_d = run_start_q;
                        best_len_d   = run_len_q;
                    end
                    run_len_d = '0;
                    state_d   = StStep;
                end else if (chk_q == CheckW'(NCHECK - 1)) begin
                    if (run_len_q == '0) begin
                        run_start_d = tap_cur_q;
                    end
                    run_len_d = run_len_q + 9'd1;
                    state_d   = StStep;
                end else begin
                    chk_d = chk_q + 1'b1;
                end
            end
            StStep: begin
                if (tap_cur_q < 9'(TAPS - 1)) begin
                    del_ce_d  = 1'b1;
                    tap_cur_d = tap_cur_q + 9'd1;
                    wait_d    = WaitW'(SETTLE);
                    state_d   = StScanWait;
                end else begin
                    // An eye touching the last tap is still open; close it here.
                    if (run_len_q > best_len_q) begin
                        best_start_d = run_start_q;
                        best_len_d   = run_len_q;
                    end
                    run_len_d = '0;
                    state_d   = StSetRst;
                end
            end
            StSetRst: begin
                if (best_len_q == '0) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    del_rst_d = 1'b1;
                    target_d  = best_start_q + (best_len_q >> 1);
                    inc_d     = '0;
                    wait_d    = WaitW'(SETTLE);
                    state_d   = StSetInc;
                end
            end
            StSetInc: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else if (inc_q != target_q) begin
                    del_ce_d = 1'b1;
                    inc_d    = inc_q + 9'd1;
                    wait_d   = WaitW'(SETTLE);
                end else begin
                    tap_d   = target_q[7:0];
                    wait_d  = WaitW'(SETTLE);
                    state_d = StSlipWait;
                end
            end
            StSlipWait: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    chk_d   = '0;
                    state_d = StSlipChk;
                end
            end
            StSlipChk: begin
                if (!match_exact) begin
                    if (slip_q < SlipW'(NSLIP)) begin
                        bs_d    = 1'b1;
                        slip_d  = slip_q + 1'b1;
                        state_d = StSlip;
                    end else begin
                        err_d   = 1'b1;
                        tap_d   = '0;
                        state_d = StFin;
                    end
                end else if (chk_q == CheckW'(NCHECK - 1)) begin
                    state_d = StFin;
                end else begin
                    chk_d = chk_q + 1'b1;
                end
            end
            StSlip: begin
                wait_d  = WaitW'(SETTLE - 1);
                state_d = StSlipWait;
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            chk_q        <= '0;
            slip_q       <= '0;
            tap_cur_q    <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            target_q     <= '0;
            inc_q        <= '0;
            bs_q         <= 1'b0;
            del_ce_q     <= 1'b0;
            del_rst_q    <= 1'b0;
            del_cal_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tap_q        <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            chk_q        <= chk_d;
            slip_q       <= slip_d;
            tap_cur_q    <= tap_cur_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            target_q     <= target_d;
            inc_q        <= inc_d;
            bs_q         <= bs_d;
            del_ce_q     <= del_ce_d;
            del_rst_q    <= del_rst_d;
            del_cal_q    <= del_cal_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            tap_q        <= tap_d;
        end
    end

    assign bs      = bs_q;
    assign del_ce  = del_ce_q;
    assign del_rst = del_rst_q;
    assign del_cal = del_cal_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign tap     = tap_q;

endmodule

// File: tb/tb_adc_lane_align.sv
// Scoreboard bench for adc_lane_align: a behavioural lane (IODELAY eye + bitslip rotation)
// drives DIN, and a monitor checks each finished training against the queued expectation.
module tb_adc_lane_align;

    localparam logic [5:0] PAT      = 6'b111000;
    localparam int         TAPS     = 64;
    localparam int         NCHECK   = 8;
    localparam int         SETTLE   = 4;
    localparam int         CAL_WAIT = 8;
    localparam int         NSLIP    = 6;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] din;
    logic       bs, del_ce, del_rst, del_cal, busy, done, err;
    logic [7:0] tap;

    adc_lane_align #(
        .PATTERN (PAT),
        .TAPS    (TAPS),
        .NCHECK  (NCHECK),
        .SETTLE  (SETTLE),
        .CAL_WAIT(CAL_WAIT),
        .NSLIP   (NSLIP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .din    (din),
        .bs     (bs),
        .del_ce (del_ce),
        .del_rst(del_rst),
        .del_cal(del_cal),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .tap    (tap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       err;
        logic [7:0] tap;
        int         n_bs;
        int         n_ce;
        int         n_rst;
        int         n_cal;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    // Lane configuration written by the stimulus, read by the lane model.
    bit cfg_good[TAPS];
    int cfg_rot;
    bit cfg_noalign;
    int cfg_corrupt;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [5:0] rot_left(input logic [5:0] w, input int n);
        logic [11:0] d;
        d = {w, w};
        return d[11-n -: 6];
    endfunction

    function automatic logic [5:0] junk();
        logic [5:0] w;
        w = 6'($urandom);
        for (int i = 0; i < 6; i++) if (w == rot_left(PAT, i)) return 6'b101010;
        return w;
    endfunction

    // Reference: widest eye (earliest on ties), centre it, count slips to frame.
    function automatic exp_t model();
        exp_t e;
        bit   g[TAPS];
        int   best_s, best_l, tgt;
        best_s = 0;
        best_l = 0;
        for (int t = 0; t < TAPS; t++) g[t] = cfg_good[t] && (t != cfg_corrupt);
        for (int t = 0; t < TAPS; t++) begin
            if (g[t] && ((t == 0) ? 1'b1 : !g[t-1])) begin
                int l;
                l = 0;
                while (t + l < TAPS && g[t+l]) l++;
                if (l > best_l) begin
                    best_l = l;
                    best_s = t;
                end
            end
        end
        e.n_cal = 1;
        if (best_l == 0) begin
            e.err = 1'b1; e.tap = 8'd0; e.n_bs = 0; e.n_ce = TAPS - 1; e.n_rst = 1;
        end else begin
            tgt     = best_s + best_l / 2;
            e.n_ce  = TAPS - 1 + tgt;
            e.n_rst = 2;
            if (cfg_noalign) begin
                e.err = 1'b1; e.tap = 8'd0; e.n_bs = NSLIP;
            end else begin
                e.err = 1'b0; e.tap = 8'(tgt); e.n_bs = (6 - cfg_rot) % 6;
            end
        end
        return e;
    endfunction

    task automatic clear_cfg();
        for (int t = 0; t < TAPS; t++) cfg_good[t] = 1'b0;
        cfg_rot     = 0;
        cfg_noalign = 1'b0;
        cfg_corrupt = -1;
    endtask

    task automatic add_eye(input int lo, input int hi);
        for (int t = lo; t <= hi && t < TAPS; t++) cfg_good[t] = 1'b1;
    endtask

    // Lane model: tracks the delay tap and bitslip count from the strobes.
    int lane_tap;
    int lane_slips;
    int lane_since;
    bit lane_corrupted;
    initial begin
        din            = '0;
        lane_tap       = 0;
        lane_slips     = 0;
        lane_since     = 0;
        lane_corrupted = 1'b0;
        forever begin
            @(negedge clk);
            if (del_cal) begin
                lane_slips     = 0;
                lane_corrupted = 1'b0;
            end
            if (del_rst) lane_tap = 0;
            else if (del_ce) lane_tap++;
            if (bs) lane_slips++;
            if (bs || del_ce || del_rst || del_cal) lane_since = 0;
            else lane_since++;
            if (lane_tap < TAPS && cfg_good[lane_tap]) begin
                if (lane_tap == cfg_corrupt && lane_since == SETTLE + 2 && !lane_corrupted) begin
                    din            = junk();
                    lane_corrupted = 1'b1;
                end else if (cfg_noalign) begin
                    din = rot_left(PAT, cfg_rot);
                end else begin
                    din = rot_left(PAT, (cfg_rot + lane_slips) % 6);
                end
            end else begin
                din = junk();
            end
        end
    end

    // Monitor: counts strobes, checks spacing, compares on each DONE rising edge.
    int   mon_bs, mon_ce, mon_rst, mon_cal, mon_since, mon_viol, mon_nh;
    logic mon_done_prev;
    exp_t mon_e;
    initial begin
        mon_bs = 0; mon_ce = 0; mon_rst = 0; mon_cal = 0;
        mon_since = 1000; mon_viol = 0; mon_done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_bs = 0; mon_ce = 0; mon_rst = 0; mon_cal = 0;
                mon_since = 1000; mon_viol = 0; mon_done_prev = 1'b0;
            end else begin
                mon_nh = int'(bs) + int'(del_ce) + int'(del_rst) + int'(del_cal);
                if (mon_nh > 1) mon_viol++;
                if (mon_nh >= 1) begin
                    if (mon_since < SETTLE) mon_viol++;
                    mon_since = 0;
                end else begin
                    mon_since++;
                end
                mon_bs  += int'(bs);
                mon_ce  += int'(del_ce);
                mon_rst += int'(del_rst);
                mon_cal += int'(del_cal);
                if (done && !mon_done_prev) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("err", int'(err), int'(mon_e.err));
                        check("tap", int'(tap), int'(mon_e.tap));
                        check("bs_pulses", mon_bs, mon_e.n_bs);
                        check("ce_pulses", mon_ce, mon_e.n_ce);
                        check("rst_pulses", mon_rst, mon_e.n_rst);
                        check("cal_pulses", mon_cal, mon_e.n_cal);
                        check("strobe_spacing_violations", mon_viol, 0);
                        check("busy_at_done", int'(busy), 0);
                    end
                    mon_bs = 0; mon_ce = 0; mon_rst = 0; mon_cal = 0; mon_viol = 0;
                end
                mon_done_prev = done;
            end
        end
    end

    task automatic run_training(input bit extra_start, input bit check_clear);
        int cyc;
        sb_q.push_back(model());
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (check_clear) begin
            check("restart_del_cal", int'(del_cal), 1);
            check("restart_done_cleared", int'(done), 0);
            check("restart_err_cleared", int'(err), 0);
        end
        if (extra_start) begin
            repeat (40) @(negedge clk);
            check("busy_mid_training", int'(busy), 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            check("training_timeout", 0, 1);
            if (sb_q.size() > 0) void'(sb_q.pop_back());
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_cfg();
        repeat (3) @(negedge clk);
        check("reset_strobes_status", int'({bs, del_ce, del_rst, del_cal, busy, done, err}), 0);
        check("reset_tap", int'(tap), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Eye 10..19, rotated by 2; also a START while busy
        clear_cfg(); add_eye(10, 19); cfg_rot = 2;
        run_training(1'b1, 1'b0);

        // No good tap at all
        clear_cfg();
        run_training(1'b0, 1'b0);

        // Restart after an error; eyes 5..8 and 30..39
        clear_cfg(); add_eye(5, 8); add_eye(30, 39); cfg_rot = 0;
        run_training(1'b0, 1'b1);

        // Equal eyes: earliest wins
        clear_cfg(); add_eye(5, 8); add_eye(20, 23); cfg_rot = 5;
        run_training(1'b0, 1'b0);

        // Eye touching the last tap
        clear_cfg(); add_eye(56, 63); cfg_rot = 3;
        run_training(1'b0, 1'b0);

        // One corrupted word at tap 12 splits the eye
        clear_cfg(); add_eye(10, 19); cfg_rot = 1; cfg_corrupt = 12;
        run_training(1'b0, 1'b0);

        // Lane never frame-aligns
        clear_cfg(); add_eye(10, 19); cfg_rot = 2; cfg_noalign = 1'b1;
        run_training(1'b0, 1'b0);

        // Reset during the scan
        clear_cfg(); add_eye(10, 19); cfg_rot = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        check("busy_before_reset", int'(busy), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_strobes_status", int'({bs, del_ce, del_rst, del_cal, busy, done, err}), 0);
        check("midreset_tap", int'(tap), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Recovery after reset
        clear_cfg(); add_eye(10, 19); cfg_rot = 4;
        run_training(1'b0, 1'b0);

        // Randomised eyes and rotations
        for (int r = 0; r < 3; r++) begin
            int n_eyes, lo;
            clear_cfg();
            n_eyes = int'($urandom_range(1, 3));
            for (int k = 0; k < n_eyes; k++) begin
                lo = int'($urandom_range(0, 60));
                add_eye(lo, lo + int'($urandom_range(0, 11)));
            end
            cfg_rot = int'($urandom_range(0, 5));
            run_training(1'b0, 1'b0);
        end

        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
